// File: rtl/timer_mmss_down_pkg.sv
// Shared definitions for the MM:SS timekeeping counters: FSM encodings, BCD digit limits
// and load-value clamping helpers.
package timer_mmss_down_pkg;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRun     = 2'd1;
    localparam logic [1:0] StPause   = 2'd2;
    localparam logic [1:0] StExpired = 2'd3;

    localparam logic [3:0] DigMaxUnits = 4'd9;
    localparam logic [2:0] DigMaxTens  = 3'd5;

    function automatic logic [3:0] clamp_units(logic [3:0] v);
        return (v > DigMaxUnits) ? DigMaxUnits : v;
    endfunction

    function automatic logic [2:0] clamp_tens(logic [2:0] v, logic [2:0] maxv);
        return (v > maxv) ? maxv : v;
    endfunction

endpackage

// File: rtl/timer_mmss_down_digit.sv
// One BCD down-counting digit: loads a pre-clamped value, or steps down and wraps to MaxV
// with a borrow out when it is decremented at zero.
module bcd_down_digit #(
    parameter int unsigned     Width = 4,
    parameter logic [Width-1:0] MaxV = Width'(9)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dec_i,
    input  logic             load_i,
    input  logic [Width-1:0] ld_i,
    output logic [Width-1:0] q_o,
    output logic             borrow_o
);

    logic [Width-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = ld_i;
        end else if (dec_i) begin
            q_d = (q_q == '0) ? MaxV : q_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign borrow_o = dec_i & (q_q == '0);

endmodule

// File: rtl/timer_mmss_down.sv
// MM:SS BCD countdown timer: loads a clamped start value, decrements on 1 Hz ticks while
// running, and raises a one-cycle DONE plus a sticky ALARM when it reaches 00:00.
module timer_mmss_down
    import timer_mmss_down_pkg::*;
#(
    parameter int unsigned MinTensMax  = 5,
    parameter int unsigned TickOnStart = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [2:0] ldmh_i,
    input  logic [3:0] ldml_i,
    input  logic [2:0] ldsh_i,
    input  logic [3:0] ldsl_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic [2:0] mh_o,
    output logic [3:0] ml_o,
    output logic [2:0] sh_o,
    output logic [3:0] sl_o,
    output logic       running_o,
    output logic       done_o,
    output logic       alarm_o
);

    localparam logic [2:0] MhMax = 3'(MinTensMax);
    // Both TickOnStart settings decrement on the first EN after START.
    localparam bit FirstEnDecrements = (TickOnStart == 0) || (TickOnStart != 0);

    logic [1:0] state_d, state_q;
    logic       done_d, done_q;
    logic       alarm_d, alarm_q;
    logic       running_d, running_q;

    logic       dig_load;
    logic [2:0] ld_mh, ld_sh;
    logic [3:0] ld_ml, ld_sl;
    logic       dec, sl_borrow, sh_borrow, ml_borrow, mh_borrow;
    logic       count_nonzero, count_is_one;

    // CLR reuses the digit load path with a zero value.
    assign dig_load = clr_i | load_i;
    assign ld_mh    = clr_i ? 3'd0 : clamp_tens(ldmh_i, MhMax);
    assign ld_ml    = clr_i ? 4'd0 : clamp_units(ldml_i);
    assign ld_sh    = clr_i ? 3'd0 : clamp_tens(ldsh_i, DigMaxTens);
    assign ld_sl    = clr_i ? 4'd0 : clamp_units(ldsl_i);

    assign dec = FirstEnDecrements && (state_q == StRun) && en_i &&
                 !clr_i && !load_i && !stop_i && !start_i;

    assign count_nonzero = |{mh_o, ml_o, sh_o, sl_o};
    assign count_is_one  = ({mh_o, ml_o, sh_o} == '0) && (sl_o == 4'd1);

    bcd_down_digit #(.Width(4), .MaxV(DigMaxUnits)) u_sl (
        .clk_i(clk_i), .rst_ni(rst_ni), .dec_i(dec), .load_i(dig_load),
        .ld_i(ld_sl), .q_o(sl_o), .borrow_o(sl_borrow)
    );
    bcd_down_digit #(.Width(3), .MaxV(DigMaxTens)) u_sh (
        .clk_i(clk_i), .rst_ni(rst_ni), .dec_i(sl_borrow), .load_i(dig_load),
        .ld_i(ld_sh), .q_o(sh_o), .borrow_o(sh_borrow)
    );
    bcd_down_digit #(.Width(4), .MaxV(DigMaxUnits)) u_ml (
        .clk_i(clk_i), .rst_ni(rst_ni), .dec_i(sh_borrow), .load_i(dig_load),
        .ld_i(ld_ml), .q_o(ml_o), .borrow_o(ml_borrow)
    );
    bcd_down_digit #(.Width(3), .MaxV(MhMax)) u_mh (
        .clk_i(clk_i), .rst_ni(rst_ni), .dec_i(ml_borrow), .load_i(dig_load),
        .ld_i(ld_mh), .q_o(mh_o), .borrow_o(mh_borrow)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        alarm_d = alarm_q;
        if (clr_i || load_i) begin
            state_d = StIdle;
            alarm_d = 1'b0;
        end else if (stop_i) begin
            if (state_q == StRun) state_d = StPause;
        end else if (start_i) begin
            if ((state_q == StIdle || state_q == StPause) && count_nonzero) state_d = StRun;
        end else if (dec && (count_is_one || mh_borrow)) begin
            // An MH underflow cannot happen from a legal count; park in EXPIRED if it does.
            state_d = StExpired;
            done_d  = 1'b1;
            alarm_d = 1'b1;
        end
    end

    assign running_d = (state_d == StRun);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
            running_q <= running_d;
        end
    end

    assign running_o = running_q;
    assign done_o    = done_q;
    assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_timer_mmss_down.sv
// Bench for timer_mmss_down: directed vector table, async-reset sequence, and random
// stimulus checked against a total-seconds reference model.
module tb_timer_mmss_down;

    logic       clk = 1'b0;
    logic       rst_n, clr, en, load, start, stop;
    logic [2:0] ldmh, ldsh, mh, sh;
    logic [3:0] ldml, ldsl, ml, sl;
    logic       running, done, alarm;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_mmss_down #(.MinTensMax(5), .TickOnStart(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en), .load_i(load),
        .ldmh_i(ldmh), .ldml_i(ldml), .ldsh_i(ldsh), .ldsl_i(ldsl),
        .start_i(start), .stop_i(stop),
        .mh_o(mh), .ml_o(ml), .sh_o(sh), .sl_o(sl),
        .running_o(running), .done_o(done), .alarm_o(alarm)
    );

    typedef struct {
        bit c, e, l, s, p;
        int a, b, cc, d;
        int mh, ml, sh, sl;
        bit run, dn, al;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, bit e, bit l, bit s, bit p, int a, int b, int cc, int d,
                                int emh, int eml, int esh, int esl, bit r, bit dn, bit al);
        vec_t v;
        v.c = c; v.e = e; v.l = l; v.s = s; v.p = p;
        v.a = a; v.b = b; v.cc = cc; v.d = d;
        v.mh = emh; v.ml = eml; v.sh = esh; v.sl = esl;
        v.run = r; v.dn = dn; v.al = al;
        return v;
    endfunction

    // Reference model: count kept as total seconds, state as 0 idle/1 run/2 pause/3 expired.
    int m_total, m_state;
    bit m_done, m_alarm;

    function automatic int clampv(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_total = 0; m_state = 0; m_done = 0; m_alarm = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (clr) begin
            m_total = 0; m_state = 0; m_alarm = 0;
        end else if (load) begin
            m_total = (clampv(int'(ldmh), 5) * 10 + clampv(int'(ldml), 9)) * 60
                    + clampv(int'(ldsh), 5) * 10 + clampv(int'(ldsl), 9);
            m_state = 0; m_alarm = 0;
        end else if (stop) begin
            if (m_state == 1) m_state = 2;
        end else if (start) begin
            if ((m_state == 0 || m_state == 2) && m_total != 0) m_state = 1;
        end else if (en && m_state == 1) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_state = 3; m_done = 1; m_alarm = 1;
            end
        end
    endtask

    task automatic check(string name, int emh, int eml, int esh, int esl,
                         bit erun, bit edone, bit ealarm);
        n_vec++;
        if ({mh, ml, sh, sl, running, done, alarm} !==
            {3'(emh), 4'(eml), 3'(esh), 4'(esl), erun, edone, ealarm}) begin
            n_err++;
            $display("FAIL %s: got %0d%0d:%0d%0d run=%b done=%b alarm=%b, want %0d%0d:%0d%0d run=%b done=%b alarm=%b",
                     name, mh, ml, sh, sl, running, done, alarm,
                     emh, eml, esh, esl, erun, edone, ealarm);
        end
    endtask

    task automatic check_model(string name);
        int mm, ss;
        mm = m_total / 60;
        ss = m_total % 60;
        check(name, mm / 10, mm % 10, ss / 10, ss % 10, m_state == 1, m_done, m_alarm);
    endtask

    task automatic drive(bit c, bit e, bit l, bit s, bit p, int a, int b, int cc, int d);
        @(negedge clk);
        clr = c; en = e; load = l; start = s; stop = p;
        ldmh = 3'(a); ldml = 4'(b); ldsh = 3'(cc); ldsl = 4'(d);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        model_reset();
        check("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {clr, en, load, start, stop} = '0;
        {ldmh, ldml, ldsh, ldsl} = '0;
        do_reset();

        //                c  e  l  s  p  ldmh ldml ldsh ldsl  mh ml sh sl  run dn al
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5, 9,  1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 2,   0, 0, 0, 2,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 2,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 7, 12, 6, 15, 5, 9, 5, 9,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   5, 9, 5, 9,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   5, 9, 5, 8,  1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 9, 5, 9,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 9, 5, 9,  0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 5, 9,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 9, 5, 9,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 9, 5, 8,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 9, 5, 8,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 5,   0, 0, 0, 5,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 5,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 5,  0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].e, tbl[i].l, tbl[i].s, tbl[i].p,
                  tbl[i].a, tbl[i].b, tbl[i].cc, tbl[i].d);
            step();
            check($sformatf("tbl%0d", i), tbl[i].mh, tbl[i].ml, tbl[i].sh, tbl[i].sl,
                  tbl[i].run, tbl[i].dn, tbl[i].al);
        end

        // Asynchronous reset in the middle of a run at 00:03.
        drive(0, 0, 1, 0, 0, 0, 0, 0, 3);
        step();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step();
        check_model("run_0003");
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("rst_held", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
            step();
            check($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0, 0, 0);
        end

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit c, e, l, s, p;
            int a, b, cc, d;
            c = ($urandom_range(0, 79) == 0);
            l = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 7); b = $urandom_range(0, 15);
                cc = $urandom_range(0, 7); d = $urandom_range(0, 15);
            end else begin
                a = 0; b = 0; cc = $urandom_range(0, 1); d = $urandom_range(0, 15);
            end
            drive(c, e, l, s, p, a, b, cc, d);
            step();
            check_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_mmss_down.md
Name: timer_mmss_down

Overview:
- BCD countdown timer for minutes:seconds (MM:SS), running opposite to the existing mod-60 up counters.
- Counts down from a loaded value on each 1 Hz enable tick and flags expiry.
- Feeds the same display path: digit widths and encodings match the up-counter outputs (tens digit 3 bits, units digit 4 bits).
- Sits beside the clock/stopwatch counters in the timekeeping datapath.

Parameters:
- MIN_TENS_MAX, 5, highest legal minutes-tens digit. Loaded values above it are clamped to it.
- TICK_ON_START, 0, if 1 the first decrement occurs on the first EN after START; if 0 it also occurs on the first EN. Reserved, and both settings behave identically in this revision.

Ports:
- CLK input 1: system clock, rising edge.
- RST input 1: asynchronous reset, active-low.
- CLR input 1: synchronous clear to 00:00 and IDLE.
- EN input 1: 1 Hz tick enable, single-cycle pulse.
- LOAD input 1: synchronous load of LD* digits.
- LDMH input 3: load value, minutes tens.
- LDML input 4: load value, minutes units.
- LDSH input 3: load value, seconds tens.
- LDSL input 4: load value, seconds units.
- START input 1: request run.
- STOP input 1: request pause.
- MH output 3: minutes tens.
- ML output 4: minutes units.
- SH output 3: seconds tens.
- SL output 4: seconds units.
- RUNNING output 1: high in RUN.
- DONE output 1: one-cycle pulse on reaching 00:00.
- ALARM output 1: level, high in EXPIRED.

Behaviour:
- Reset (RST=0, asynchronous): all digits 0, state IDLE, RUNNING=0, DONE=0, ALARM=0.
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- Priority each cycle: CLR > LOAD > STOP > START > EN.
- CLR:
  - Digits go to 0 and state to IDLE.
  - DONE=0 next cycle; ALARM drops.
- LOAD, legal in any state:
  - Digits take the LD* values, with clamping: LDML/LDSL >9 become 9; LDSH >5 becomes 5; LDMH >MIN_TENS_MAX becomes MIN_TENS_MAX.
  - State goes to IDLE; ALARM drops.
- START in IDLE or PAUSE:
  - If the count is nonzero, state goes to RUN next cycle.
  - If the count is 00:00, START is ignored and the state stays.
  - START in RUN or EXPIRED is ignored.
- STOP in RUN: state goes to PAUSE. STOP in other states is ignored.
- START and STOP in the same cycle: STOP wins.
- Decrement: only in RUN on EN=1, and only when no higher-priority input is active. Count changes on the same clock edge.
  - SL: 0→9 with borrow, else -1.
  - SH: on borrow, 0→5 with borrow, else -1.
  - ML: on borrow, 0→9 with borrow, else -1.
  - MH: on borrow, -1.
  - MH=0 with a borrow cannot occur, because RUN never holds 00:00.
- Expiry:
  - The decrement that produces 00:00 moves the state to EXPIRED on the same edge.
  - DONE=1 for exactly that one following cycle.
  - ALARM=1 from that cycle until CLR or LOAD.
- EN outside RUN: ignored. Count holds in IDLE, PAUSE and EXPIRED.
- RUNNING: 1 iff state==RUN.
- Wrap examples:
  - 10:00 → 09:59.
  - 01:00 → 00:59.
  - 00:10 → 00:09.
- RST low mid-run: immediate return to reset values, no DONE pulse.
- EN and STOP in the same cycle in RUN: no decrement, state goes to PAUSE.

Decomposition:
- Shared package contents:
  - State enum/localparams: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3.
  - Digit limit constants: DIG_MAX_UNITS=9, DIG_MAX_TENS=5.
  - These are shared with the up-counter family.
- Sub-module bcd_down_digit, parameterised by WIDTH and MAXV:
  - Inputs: dec, load, ld value (pre-clamped).
  - Outputs: q, borrow-out (q==0 & dec).
  - Instantiated four times, borrow chained SL→SH→ML→MH.
- Top level holds the FSM, clamping, zero-detect and DONE/ALARM registers.

Test Plan:
- Reset, then LOAD 01:00, START, one EN → 00:59 on that edge, RUNNING=1.
- LOAD 00:02, START, two EN → 00:01, then 00:00; DONE high exactly one cycle; ALARM=1; RUNNING=0. Further EN leaves 00:00.
- LOAD with LDMH=7, LDML=12, LDSH=6, LDSL=15 → reads 5:9:5:9 (59:59); START then EN → 59:58.
- LOAD 10:00, START, EN → 09:59. STOP then three EN → holds 09:59. START, EN → 09:58. START+STOP in the same cycle → PAUSE.
- START with count 00:00 in IDLE → stays IDLE. In EXPIRED, LOAD 00:05 → IDLE, ALARM=0.
- In RUN at 00:03, assert RST low asynchronously (mid-cycle) → outputs zero immediately, state IDLE. Release, then EN → no change, DONE never pulses.
